softmax_out_writer: RTL and testbench
=====================================

Name: softmax_out_writer

Overview:
- Write-back engine for the softmax datapath.
- Accepts the four 16-bit softmax results per beat (outp0..outp3) over a valid/ready handshake and buffers them in a small FIFO.
- Packs each beat into one NUM*DATAWIDTH memory word and writes words to consecutive addresses from start_addr to end_addr through a single write port (addr/d0/we0).
- It is the writer counterpart of the input-fetch side that reads the same on-chip RAM layout.

Parameters:
- DATAWIDTH, 16, width of one FP16 element (SIGN+EXPONENT+MANTISSA).
- NUM, 4, elements per memory word.
- ADDRSIZE, 16, memory address width.
- FIFO_DEPTH, 4, buffered beats; power of two, >=2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- init  input  1  synchronous active-high soft clear; same effect as reset.
- start  input  1  one-cycle pulse; latches start_addr/end_addr and begins a run.
- start_addr  input  ADDRSIZE  first write address.
- end_addr  input  ADDRSIZE  last write address, inclusive.
- in_valid  input  1  outp0..outp3 hold a valid beat.
- in_ready  output  1  writer accepts a beat this cycle.
- outp0..outp3  input  DATAWIDTH each  softmax results; outp0 maps to d0[DATAWIDTH-1:0], outp3 to the MSBs.
- mem_stall  input  1  memory cannot take a write this cycle.
- addr  output  ADDRSIZE  write address (registered).
- d0  output  DATAWIDTH*NUM  write data (registered).
- we0  output  1  write strobe (registered).
- busy  output  1  run in progress.
- done  output  1  all words written; held high.
- err  output  1  one-cycle pulse when start is given with end_addr < start_addr.

Behaviour:
- Reset/init: when reset==0 or init==1 at a clock edge, the following take these values:
  - state=IDLE
  - FIFO emptied
  - addr=0, d0=0, we0=0
  - in_ready=0, busy=0, done=0, err=0
  - internal counters cleared.
- Reset/init take priority over every other input.
- A reset mid-run abandons the run. Words already presented on we0 are considered written; nothing further is issued.
- States:
  - IDLE: waits for start.
    - start with end_addr>=start_addr → RUN. Latch bounds, wr_addr=start_addr, accept_cnt=0, done=0.
    - start with end_addr<start_addr → DONE with no writes, and err pulses for one cycle.
  - RUN: accept and drain. Move to DONE on the edge where the word for end_addr is issued (we0 goes high with addr==end_addr).
  - DONE: done=1, busy=0. start re-launches exactly as from IDLE; done clears on that edge.
- busy=1 only in RUN.
- Accept side:
  - in_ready = RUN && FIFO not full && accept_cnt < (end_addr-start_addr+1).
  - A beat transfers on an edge with in_valid && in_ready.
  - Beats offered outside this window are ignored and never stored.
  - Count arithmetic uses ADDRSIZE+1 bits, so start=0, end=0xFFFF gives 65536 words with no overflow.
- Drain side:
  - Each cycle in RUN with FIFO non-empty and mem_stall==0: pop the head; register we0=1, addr=wr_addr, d0=head; then wr_addr+=1.
  - Otherwise we0=0. addr and d0 hold their last values.
- Latency: a beat accepted at edge k is visible on we0/addr/d0 after edge k+1 at the earliest, i.e. one cycle.
- Simultaneous push and pop in the same cycle is allowed.
  - Full is evaluated before the pop, so no push occurs when the FIFO is full.
  - Pushing into an empty FIFO does not bypass it.
- mem_stall held indefinitely holds we0=0 and stalls draining. Accepting continues until the FIFO is full.
- Ordering: words are written strictly in acceptance order at strictly increasing addresses.
- start pulses while in RUN are ignored.

Test Plan:
- Basic run: reset low 2 cycles; start with start_addr=2, end_addr=4; three beats with in_valid held, outp0..3 = 0x3C00,0x4000,0x4200,0x4400 then +1 per beat → we0 high at addr 2,3,4 with d0=0x4400_4200_4000_3C00 etc.; done=1 the cycle after addr 4 is written; in_ready=0 after the third accept.
- Backpressure: mem_stall=1 for 10 cycles during a 6-word run (addr 0..5) → in_ready drops after 4 accepts (FIFO_DEPTH=4), no we0 while stalled; after release, six writes occur in order with no loss or duplication.
- Single word and error: start=end=7 → exactly one write at addr 7, then done. Next, start with start_addr=9, end_addr=8 → err pulses once, done=1, zero writes.
- Reset mid-run: assert reset=0 after 2 of 5 writes → next cycle we0=0, busy=0, done=0, in_ready=0; a new start runs cleanly from its start_addr.
- Throughput and re-launch: in_valid continuous, mem_stall=0, 8 words → one write per cycle, we0 high 8 consecutive cycles with 1-cycle latency. A start while in DONE re-launches; a start pulse while in RUN has no effect.

Source files
------------

// File: rtl/softmax_out_writer_if.sv
// Beat stream and memory write-port bundle for softmax_out_writer.
//   in_valid/in_ready/outp0..outp3 : producer -> writer beat handshake
//   mem_stall                       : memory back-pressure
//   addr/d0/we0                     : registered single write port
// slave  : writer side (consumes beats, drives the write port)
// master : environment side (producer + memory)
interface softmax_out_writer_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NUM       = 4,
  parameter int unsigned ADDRSIZE  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATAWIDTH-1:0]      outp0;
  logic [DATAWIDTH-1:0]      outp1;
  logic [DATAWIDTH-1:0]      outp2;
  logic [DATAWIDTH-1:0]      outp3;
  logic                      mem_stall;
  logic [ADDRSIZE-1:0]       addr;
  logic [DATAWIDTH*NUM-1:0]  d0;
  logic                      we0;

  modport slave (
    input  in_valid, outp0, outp1, outp2, outp3, mem_stall,
    output in_ready, addr, d0, we0
  );

  modport master (
    output in_valid, outp0, outp1, outp2, outp3, mem_stall,
    input  in_ready, addr, d0, we0
  );
endinterface

// File: rtl/softmax_out_writer.sv
// softmax_out_writer: write-back engine for the softmax datapath.
// Accepts beats of four DATAWIDTH results, buffers them in a FIFO_DEPTH
// FIFO and writes each beat as one packed word (outp0 in the LSBs) to
// consecutive addresses start_addr..end_addr (inclusive).
// Ports:
//   clk, reset (sync, active-low), init (sync, active-high soft clear)
//   start, start_addr, end_addr : launch a run and its address bounds
//   bus (slave)                 : beat handshake + memory write port
//   busy  : run in progress
//   done  : all words written (held until relaunch/reset)
//   err   : one-cycle pulse on start with end_addr < start_addr
module softmax_out_writer #(
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned NUM        = 4,
  parameter int unsigned ADDRSIZE   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 start,
  input  logic [ADDRSIZE-1:0]  start_addr,
  input  logic [ADDRSIZE-1:0]  end_addr,
  softmax_out_writer_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int unsigned WW = DATAWIDTH * NUM;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic                clr;
  logic [ADDRSIZE-1:0] end_q;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE:0]   total_q;
  logic [ADDRSIZE:0]   accept_cnt;
  logic [WW-1:0]       fifo_mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]         wptr;
  logic [PW:0]         rptr;
  logic [WW-1:0]       word_in;
  logic                full, empty, rdy, push, pop, last_pop;
  logic                can_start, launch, bad_start;

  assign clr     = !reset || init;
  assign word_in = {bus.outp3, bus.outp2, bus.outp1, bus.outp0};

  always_comb begin
    can_start = (state == IDLE) || (state == DONE);
    launch    = start && can_start && (end_addr >= start_addr);
    bad_start = start && can_start && (end_addr < start_addr);
    empty     = (wptr == rptr);
    full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    rdy       = (state == RUN) && !full && (accept_cnt < total_q);
    push      = bus.in_valid && rdy;
    pop       = (state == RUN) && !empty && !bus.mem_stall;
    last_pop  = pop && (wr_addr == end_q);
  end

  assign bus.in_ready = rdy;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (launch)         state_n = RUN;
        else if (bad_start) state_n = DONE;
      end
      RUN:     if (last_pop) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[PW-1:0]] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr       <= '0;
      rptr       <= '0;
      end_q      <= '0;
      wr_addr    <= '0;
      total_q    <= '0;
      accept_cnt <= '0;
      bus.addr   <= '0;
      bus.d0     <= '0;
      bus.we0    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err     <= bad_start;
      bus.we0 <= pop;
      if (launch) begin
        end_q      <= end_addr;
        wr_addr    <= start_addr;
        // One extra bit so a full 0..max range counts without overflow.
        total_q    <= {1'b0, end_addr} - {1'b0, start_addr} + (ADDRSIZE+1)'(1);
        accept_cnt <= '0;
      end
      if (push) begin
        wptr       <= wptr + (PW+1)'(1);
        accept_cnt <= accept_cnt + (ADDRSIZE+1)'(1);
      end
      if (pop) begin
        bus.addr <= wr_addr;
        bus.d0   <= fifo_mem[rptr[PW-1:0]];
        rptr     <= rptr + (PW+1)'(1);
        wr_addr  <= wr_addr + ADDRSIZE'(1);
      end
    end
  end
endmodule

// File: tb/tb_softmax_out_writer.sv
module tb_softmax_out_writer;
  logic        clk;
  logic        reset, init, start;
  logic [15:0] start_addr, end_addr;
  logic        busy, done, err;

  softmax_out_writer_if #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(16)) bus ();

  softmax_out_writer #(
    .DATAWIDTH(16), .NUM(4), .ADDRSIZE(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [63:0] d; } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int wr_count = 0;
  int cur_run = 0;
  int max_run = 0;
  int beats_sent = 0;
  logic [15:0] exp_addr;
  logic [15:0] base [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write on the port must match the head entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.we0) begin
      wr_count++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.addr), 64'(e.a));
        chk("wr_data", bus.d0, e.d);
      end
    end else begin
      cur_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pattern(input logic [15:0] b0, b1, b2, b3);
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
  endtask

  task automatic pulse_start(input logic [15:0] sa, ea);
    start_addr = sa; end_addr = ea; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] sa, ea);
    exp_addr   = sa;
    beats_sent = 0;
    pulse_start(sa, ea);
  endtask

  // Offer the next beat for one cycle; a beat seen with in_ready high
  // transfers on the coming edge, so its expected write is queued now.
  task automatic feed_cycle(input int total);
    exp_t e;
    if (beats_sent < total) begin
      bus.in_valid = 1'b1;
      bus.outp0 = base[0] + 16'(beats_sent);
      bus.outp1 = base[1] + 16'(beats_sent);
      bus.outp2 = base[2] + 16'(beats_sent);
      bus.outp3 = base[3] + 16'(beats_sent);
      if (bus.in_ready) begin
        e.a = exp_addr;
        e.d = {bus.outp3, bus.outp2, bus.outp1, bus.outp0};
        exp_q.push_back(e);
        exp_addr++;
        beats_sent++;
      end
    end else begin
      bus.in_valid = 1'b0;
    end
    tick();
  endtask

  task automatic wait_done(input string name, input int total, input logic [15:0] ea);
    for (int c = 0; c < 300 && !done; c++) feed_cycle(total);
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy_off"}, 64'(busy), 64'd0);
    chk({name, "_last_we0"}, 64'(bus.we0), 64'd1);
    chk({name, "_last_addr"}, 64'(bus.addr), 64'(ea));
    bus.in_valid = 1'b0;
    tick();
    chk({name, "_all_written"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    reset = 1'b0; init = 1'b0; start = 1'b0;
    start_addr = '0; end_addr = '0;
    bus.in_valid = 1'b0; bus.mem_stall = 1'b0;
    bus.outp0 = '0; bus.outp1 = '0; bus.outp2 = '0; bus.outp3 = '0;
    set_pattern('0, '0, '0, '0);
    exp_addr = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_d0", bus.d0, 64'd0);
    chk("rst_we0", 64'(bus.we0), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    tick();

    // Basic run: addresses 2..4, first word 0x4400_4200_4000_3C00
    set_pattern(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
    start_run(16'd2, 16'd4);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_ready", 64'(bus.in_ready), 64'd1);
    chk("basic_first_word", {exp_q.size() == 0 ? 64'd0 : 64'd0} | 64'h4400_4200_4000_3C00,
        {16'h4400, 16'h4200, 16'h4000, 16'h3C00});
    for (int c = 0; c < 20 && beats_sent < 3; c++) feed_cycle(3);
    chk("basic_ready_after_3", 64'(bus.in_ready), 64'd0);
    wait_done("basic", 3, 16'd4);

    // Backpressure: six words under a 10-cycle stall
    bus.mem_stall = 1'b1;
    set_pattern(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    start_run(16'd0, 16'd5);
    wc = wr_count;
    repeat (10) feed_cycle(6);
    chk("bp_accepts", 64'(beats_sent), 64'd4);
    chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
    chk("bp_no_writes", 64'(wr_count - wc), 64'd0);
    bus.mem_stall = 1'b0;
    wait_done("bp", 6, 16'd5);
    chk("bp_write_count", 64'(wr_count - wc), 64'd6);

    // Beats offered while not running are never stored
    bus.in_valid = 1'b1;
    bus.outp0 = 16'hDEAD; bus.outp1 = 16'hDEAD; bus.outp2 = 16'hDEAD; bus.outp3 = 16'hDEAD;
    repeat (3) begin
      tick();
      chk("idle_ready_low", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;

    // Single word
    set_pattern(16'h5000, 16'h5100, 16'h5200, 16'h5300);
    start_run(16'd7, 16'd7);
    wc = wr_count;
    wait_done("single", 1, 16'd7);
    chk("single_count", 64'(wr_count - wc), 64'd1);

    // Error: end below start
    wc = wr_count;
    pulse_start(16'd9, 16'd8);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_done", 64'(done), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    tick();
    chk("err_clear", 64'(err), 64'd0);
    chk("err_done_held", 64'(done), 64'd1);
    chk("err_no_writes", 64'(wr_count - wc), 64'd0);

    // Reset mid-run after exactly two writes
    bus.mem_stall = 1'b1;
    set_pattern(16'h6000, 16'h6100, 16'h6200, 16'h6300);
    start_run(16'd10, 16'd14);
    repeat (6) feed_cycle(5);
    wc = wr_count;
    bus.mem_stall = 1'b0;
    feed_cycle(5);
    feed_cycle(5);
    bus.mem_stall = 1'b1;
    bus.in_valid  = 1'b0;
    reset = 1'b0;
    tick();
    chk("mid_rst_writes", 64'(wr_count - wc), 64'd2);
    chk("mid_rst_we0", 64'(bus.we0), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_dropped", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    reset = 1'b1;
    bus.mem_stall = 1'b0;
    tick();
    set_pattern(16'h7000, 16'h7100, 16'h7200, 16'h7300);
    start_run(16'd20, 16'd21);
    wait_done("post_rst", 2, 16'd21);

    // Throughput: 8 words back to back, one-cycle latency, start in RUN ignored
    set_pattern(16'h8000, 16'h8100, 16'h8200, 16'h8300);
    max_run = 0;
    start_run(16'h0100, 16'h0107);
    feed_cycle(8);
    chk("tp_no_bypass", 64'(bus.we0), 64'd0);
    feed_cycle(8);
    chk("tp_latency_we0", 64'(bus.we0), 64'd1);
    chk("tp_latency_addr", 64'(bus.addr), 64'h0100);
    start_addr = 16'h0500; end_addr = 16'h0600; start = 1'b1;
    feed_cycle(8);
    start = 1'b0;
    chk("tp_start_ignored", 64'(busy), 64'd1);
    wait_done("tp", 8, 16'h0107);
    chk("tp_consecutive", 64'(max_run), 64'd8);

    // Relaunch from DONE
    set_pattern(16'h9000, 16'h9100, 16'h9200, 16'h9300);
    start_run(16'd30, 16'd31);
    chk("relaunch_done_clr", 64'(done), 64'd0);
    chk("relaunch_busy", 64'(busy), 64'd1);
    wait_done("relaunch", 2, 16'd31);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
